// File: rtl/imm_ext_pkg.sv
// Shared format codes and opcode constants for the LEGv8 immediate extractor.
package imm_ext_pkg;

  localparam int unsigned FMT_W = 3;

  typedef enum logic [FMT_W-1:0] {
    FMT_NONE = 3'd0,
    FMT_D    = 3'd1,
    FMT_CB   = 3'd2,
    FMT_B    = 3'd3,
    FMT_I    = 3'd4,
    FMT_IM   = 3'd5
  } fmt_e;

  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;
  localparam logic [5:0]  OP_B     = 6'b000101;
  localparam logic [5:0]  OP_BL    = 6'b100101;
  localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI  = 10'b1101000100;
  localparam logic [8:0]  OP_MOVZ  = 9'b110100101;

endpackage

// File: rtl/imm_fifo.sv
// Synchronous FIFO with synchronous flush and registered full/empty flags.
module imm_fifo #(
  parameter int unsigned WIDTH = 67,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic             push;
  logic             pop;

  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else begin
      count_next = count + CW'(push) - CW'(pop);
    end
  end

  // full reads high during reset so nothing is accepted before the first clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b1;
      empty  <= 1'b1;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
      empty <= (count_next == '0);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= wr_data;
          wr_ptr      <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// LEGv8 immediate decode/extend feeding a result queue, with an unknown-encoding counter.
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned SHIFT_BRANCH = 1,
  parameter int unsigned CNT_W        = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] imm,
  output logic [FMT_W-1:0]  fmt,
  output logic [CNT_W-1:0]  unk_cnt
);

  logic [63:0]        ext64_c;
  logic [DATA_W-1:0]  imm_c;
  fmt_e               fmt_c;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic [DATA_W+2:0]  head;

  // Priority decode; everything is built at 64 bits and then truncated to DATA_W.
  always_comb begin
    ext64_c = '0;
    fmt_c   = FMT_NONE;
    if (instr[31:21] == OP_STUR || instr[31:21] == OP_LDUR) begin
      fmt_c   = FMT_D;
      ext64_c = {{55{instr[20]}}, instr[20:12]};
    end else if (instr[31:24] == OP_CBZ || instr[31:24] == OP_CBNZ ||
                 instr[31:24] == OP_BCOND) begin
      fmt_c   = FMT_CB;
      ext64_c = {{45{instr[23]}}, instr[23:5]};
      if (SHIFT_BRANCH != 0) ext64_c = ext64_c << 2;
    end else if (instr[31:26] == OP_B || instr[31:26] == OP_BL) begin
      fmt_c   = FMT_B;
      ext64_c = {{38{instr[25]}}, instr[25:0]};
      if (SHIFT_BRANCH != 0) ext64_c = ext64_c << 2;
    end else if (instr[31:22] == OP_ADDI || instr[31:22] == OP_SUBI) begin
      fmt_c   = FMT_I;
      ext64_c = {52'b0, instr[21:10]};
    end else if (instr[31:23] == OP_MOVZ) begin
      // Upper half-word positions do not exist in a 32-bit result.
      if (!(DATA_W == 32 && instr[22])) begin
        fmt_c   = FMT_IM;
        ext64_c = {48'b0, instr[20:5]} << {instr[22:21], 4'b0000};
      end
    end
  end

  assign imm_c = ext64_c[DATA_W-1:0];
  assign push  = in_valid && in_ready;

  imm_fifo #(
    .WIDTH (DATA_W + 3),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .wr_en   (in_valid),
    .wr_data ({fmt_c, imm_c}),
    .full    (fifo_full),
    .rd_en   (out_ready),
    .rd_data (head),
    .empty   (fifo_empty)
  );

  assign in_ready  = !fifo_full;
  assign out_valid = !fifo_empty;
  assign fmt       = head[DATA_W+2:DATA_W];
  assign imm       = head[DATA_W-1:0];

  // Saturating count of accepted unrecognised words; flush does not clear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unk_cnt <= '0;
    end else if (push && fmt_c == FMT_NONE && unk_cnt != '1) begin
      unk_cnt <= unk_cnt + CNT_W'(1);
    end
  end

endmodule
